// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sram_port_arbiter                                             |
// | Description: Three-client arbiter in front of one external async SRAM.     |
// |              Client 0 has fixed priority; clients 1/2 share a round-robin. |
// |              A turnaround cycle is inserted on every write->read switch.   |
// |              Optional anti-starvation for clients 1/2: SRAM_ARB_STARVE_EN  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sram_port_arbiter #(
    parameter int AW           = 20,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     oSRAM_ADDR,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N,
    inout  wire  [DW-1:0]     ioSRAM_DQ
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_TURN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_rr_ptr;      // 0: client 1 is next, 1: client 2 is next
    logic [1:0]      r_client;      // owner of the access currently on the pins
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_dq_oe;
    logic [2:0]      r_rvalid;
    logic [DW-1:0]   r_rdata;

    logic            w_rr_valid;
    logic [1:0]      w_rr_pick;
    logic            w_starve_force;
    logic            w_win_valid;
    logic [1:0]      w_win;
    logic            w_win_we;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_wdata;
    logic            w_withhold;

    // Round-robin pick between clients 1 and 2
    always_comb begin
        w_rr_valid = req[1] | req[2];
        if (req[1] && req[2]) begin
            w_rr_pick = r_rr_ptr ? 2'd2 : 2'd1;
        end else if (req[2]) begin
            w_rr_pick = 2'd2;
        end else begin
            w_rr_pick = 2'd1;
        end
    end

`ifdef SRAM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;

    assign w_starve_force = w_rr_valid && (r_starve_cnt == CW'(STARVE_LIMIT));

    // Count client-0 grants that happen while 1/2 are waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_rr_valid || gnt[1] || gnt[2]) begin
            r_starve_cnt <= '0;
        end else if (gnt[0]) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Strict priority: the limit has no effect without the counter
    assign w_starve_force = 1'b0 && (STARVE_LIMIT != 0);
`endif

    // Winner selection and its request fields
    always_comb begin
        w_win_valid = req[0] | w_rr_valid;
        w_win       = (req[0] && !w_starve_force) ? 2'd0 : w_rr_pick;
        w_win_we    = we[0];
        w_win_addr  = addr[0 +: AW];
        w_win_wdata = wdata[0 +: DW];
        case (w_win)
            2'd1: begin
                w_win_we    = we[1];
                w_win_addr  = addr[AW +: AW];
                w_win_wdata = wdata[DW +: DW];
            end
            2'd2: begin
                w_win_we    = we[2];
                w_win_addr  = addr[2*AW +: AW];
                w_win_wdata = wdata[2*DW +: DW];
            end
            default: ;
        endcase
        // A read may not follow a write on the pins directly
        w_withhold = (r_state == S_ACCESS) && !r_we_n && w_win_valid && !w_win_we;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state and grant pulse
    always_comb begin
        w_next_state = S_IDLE;
        gnt          = 3'b000;
        if (w_win_valid) begin
            if (w_withhold) begin
                w_next_state = S_TURN;
            end else begin
                w_next_state = S_ACCESS;
                gnt          = 3'b001 << w_win;
            end
        end
    end

    // Round-robin pointer moves only on client 1/2 grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_rr_ptr <= 1'b0;
        else if (gnt[1]) r_rr_ptr <= 1'b1;
        else if (gnt[2]) r_rr_ptr <= 1'b0;
    end

    // Register the granted access onto the SRAM pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_client <= 2'd0;
        end else if (|gnt) begin
            r_addr   <= w_win_addr;
            r_wdata  <= w_win_wdata;
            r_oe_n   <= w_win_we;
            r_we_n   <= !w_win_we;
            r_dq_oe  <= w_win_we;
            r_client <= w_win;
        end else begin
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
        end
    end

    // Capture read data at the end of a read access cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 3'b000;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 3'b000;
            if (r_state == S_ACCESS && !r_oe_n) begin
                r_rvalid <= 3'b001 << r_client;
                r_rdata  <= ioSRAM_DQ;
            end
        end
    end

    assign rvalid     = r_rvalid;
    assign rdata      = r_rdata;
    assign oSRAM_ADDR = r_addr;
    assign oSRAM_OE_N = r_oe_n;
    assign oSRAM_WE_N = r_we_n;
    assign oSRAM_CE_N = 1'b0;
    assign oSRAM_UB_N = 1'b0;
    assign oSRAM_LB_N = 1'b0;
    assign ioSRAM_DQ  = r_dq_oe ? r_wdata : {DW{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_sram_port_arbiter                                          |
// | Description: Directed self-checking bench for sram_port_arbiter with a     |
// |              small behavioural async SRAM on the pins. Honours the         |
// |              SRAM_ARB_STARVE_EN build option in the starvation scenario.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sram_port_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   sram_addr;
    logic            sram_oe_n, sram_we_n, sram_ce_n, sram_ub_n, sram_lb_n;
    wire  [DW-1:0]   dq;

    int n_cmp;
    int n_err;

    // Behavioural SRAM: drives read data when OE_N is low; when the bus is idle
    // it drives a marker so an unexpected DUT driver shows up as a wrong value.
    logic [DW-1:0] mem [0:255];
    assign dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] :
                ((sram_oe_n && sram_we_n) ? 16'h5A5A : 16'hzzzz);

    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= dq;
    end

    sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .oSRAM_ADDR (sram_addr),
        .oSRAM_OE_N (sram_oe_n),
        .oSRAM_WE_N (sram_we_n),
        .oSRAM_CE_N (sram_ce_n),
        .oSRAM_UB_N (sram_ub_n),
        .oSRAM_LB_N (sram_lb_n),
        .ioSRAM_DQ  (dq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b expected 000", gnt); end
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL rst_rvalid: got %b expected 000", rvalid); end
        n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
        n_cmp++; if (sram_addr !== 20'h00000) begin n_err++; $display("FAIL rst_addr: got %h expected 00000", sram_addr); end
        n_cmp++; if (sram_oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n: got %b expected 1", sram_oe_n); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b expected 1", sram_we_n); end
        n_cmp++; if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin n_err++; $display("FAIL rst_ce_ub_lb: got %b expected 000", {sram_ce_n, sram_ub_n, sram_lb_n}); end
        n_cmp++; if (dq !== 16'h5A5A) begin n_err++; $display("FAIL rst_dq_hiz: got %h expected 5a5a", dq); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        we = 3'b000;
        addr[2*AW +: AW] = 20'h00960;
        req = 3'b100;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL rd_gnt: got %b expected 100", gnt); end
        step();
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if (sram_oe_n !== 1'b0) begin n_err++; $display("FAIL rd_oe_n: got %b expected 0", sram_oe_n); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rd_we_n: got %b expected 1", sram_we_n); end
        n_cmp++; if (sram_addr !== 20'h00960) begin n_err++; $display("FAIL rd_addr: got %h expected 00960", sram_addr); end
        step();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b100) begin n_err++; $display("FAIL rd_rvalid: got %b expected 100", rvalid); end
        n_cmp++; if (rdata !== 16'h0101) begin n_err++; $display("FAIL rd_rdata: got %h expected 0101", rdata); end
        step();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL rd_rvalid_pulse: got %b expected 000", rvalid); end
        n_cmp++; if (rdata !== 16'h0101) begin n_err++; $display("FAIL rd_rdata_hold: got %h expected 0101", rdata); end
        step();
    endtask

    task automatic test_write_then_read();
        do_reset();
        we = 3'b010;
        addr[AW +: AW]  = 20'h00010;
        wdata[DW +: DW] = 16'hABCD;
        req = 3'b010;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL wr_gnt: got %b expected 010", gnt); end
        step();
        req = 3'b100;
        we  = 3'b000;
        addr[2*AW +: AW] = 20'h00010;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL wr_turn_withhold: got %b expected 000", gnt); end
        n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL wr_we_n: got %b expected 0", sram_we_n); end
        n_cmp++; if (sram_oe_n !== 1'b1) begin n_err++; $display("FAIL wr_oe_n: got %b expected 1", sram_oe_n); end
        n_cmp++; if (dq !== 16'hABCD) begin n_err++; $display("FAIL wr_dq: got %h expected abcd", dq); end
        step();
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL turn_gnt: got %b expected 100", gnt); end
        n_cmp++; if ({sram_oe_n, sram_we_n} !== 2'b11) begin n_err++; $display("FAIL turn_pins: got %b expected 11", {sram_oe_n, sram_we_n}); end
        n_cmp++; if (dq !== 16'h5A5A) begin n_err++; $display("FAIL turn_dq_hiz: got %h expected 5a5a", dq); end
        step();
        req = 3'b000;
        @(negedge clk);
        n_cmp++; if (sram_oe_n !== 1'b0 || sram_addr !== 20'h00010) begin n_err++; $display("FAIL wtr_read_pins: got oe_n=%b addr=%h expected 0/00010", sram_oe_n, sram_addr); end
        step();
        @(negedge clk);
        n_cmp++; if (rvalid !== 3'b100 || rdata !== 16'hABCD) begin n_err++; $display("FAIL wtr_rdata: got %b/%h expected 100/abcd", rvalid, rdata); end
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g [0:5];
        logic [15:0] exp_d [0:5];
        do_reset();
        we = 3'b000;
        addr[AW +: AW]   = 20'h00021;
        addr[2*AW +: AW] = 20'h00022;
        req = 3'b110;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                exp_g[k] = (k % 2 == 0) ? 3'b010 : 3'b100;
                exp_d[k] = (k % 2 == 0) ? 16'h2121 : 16'h2222;
            end
            if (k == 6) req = 3'b000;
            @(negedge clk);
            if (k < 6) begin
                n_cmp++; if (gnt !== exp_g[k]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_g[k]); end
            end
            if (k >= 1 && k <= 6) begin
                n_cmp++; if (sram_oe_n !== 1'b0) begin n_err++; $display("FAIL rr_no_idle[%0d]: got oe_n=%b expected 0", k, sram_oe_n); end
            end
            if (k >= 2) begin
                n_cmp++; if (rvalid !== exp_g[k-2] || rdata !== exp_d[k-2]) begin n_err++; $display("FAIL rr_rdata[%0d]: got %b/%h expected %b/%h", k, rvalid, rdata, exp_g[k-2], exp_d[k-2]); end
            end
            step();
        end
    endtask

    task automatic test_starve();
        logic [2:0] exp;
        do_reset();
        we  = 3'b000;
        req = 3'b111;
        for (int k = 0; k < 18; k++) begin
            exp = 3'b001;
`ifdef SRAM_ARB_STARVE_EN
            if (k == 8)  exp = 3'b010;
            if (k == 17) exp = 3'b100;
`endif
            @(negedge clk);
            n_cmp++; if (gnt !== exp) begin n_err++; $display("FAIL starve_gnt[%0d]: got %b expected %b", k, gnt, exp); end
            step();
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        we = 3'b000;
        addr[2*AW +: AW] = 20'h00060;
        req = 3'b100;
        @(negedge clk);
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL mid_gnt: got %b expected 100", gnt); end
        step();
        req = 3'b000;
        n_cmp++; if (sram_oe_n !== 1'b0) begin n_err++; $display("FAIL mid_oe_active: got %b expected 0", sram_oe_n); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({sram_oe_n, sram_we_n} !== 2'b11) begin n_err++; $display("FAIL mid_pins_async: got %b expected 11", {sram_oe_n, sram_we_n}); end
        n_cmp++; if (dq !== 16'h5A5A) begin n_err++; $display("FAIL mid_dq_hiz: got %h expected 5a5a", dq); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL mid_no_rvalid[%0d]: got %b expected 000", k, rvalid); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  waits;
        bit  got;
        do_reset();
        we = 3'b010;
        addr[0 +: AW]   = 20'h00021;
        addr[AW +: AW]  = 20'h00040;
        wdata[DW +: DW] = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            req   = 3'b011;
            waits = 0;
            got   = 1'b0;
            while (!got && waits < 5) begin
                @(negedge clk);
                if (gnt[0]) got = 1'b1;
                else        waits++;
                step();
            end
            n_cmp++;
            if (!got) begin
                n_err++; $display("FAIL b2b_timeout[%0d]: got no client-0 grant within %0d cycles", k, waits);
            end else if (waits != ((k == 0) ? 0 : 1)) begin
                n_err++; $display("FAIL b2b_delay[%0d]: got %0d wait cycles expected %0d", k, waits, (k == 0) ? 0 : 1);
            end
            req = 3'b010;
            @(negedge clk);
            n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL b2b_wr_gnt[%0d]: got %b expected 010", k, gnt); end
            step();
        end
        req = 3'b000;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0101);
        mem[8'h60] <= 16'h0101;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_round_robin();
        test_starve();
        test_reset_mid_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single external 16-bit asynchronous SRAM between three on-chip masters: the display read-out (client 0), the capture writer (client 1) and the color_transform engine (client 2). It sits between those masters and the SRAM pins, issues at most one SRAM access per cycle, and inserts a bus-turnaround cycle whenever a read follows a write. Client 0 has fixed priority; clients 1 and 2 are served round-robin, with optional anti-starvation.

## Interface
- AW, 20, SRAM word-address width
- DW, 16, SRAM data width
- STARVE_LIMIT, 8, consecutive client-0 grants tolerated while 1/2 wait (used only with SRAM_ARB_STARVE_EN)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  3  per-client request, bit i = client i
- we  in  3  per-client access type, 1 = write, 0 = read
- addr  in  3*AW  per-client address, client i at [i*AW +: AW]
- wdata  in  3*DW  per-client write data, client i at [i*DW +: DW]
- gnt  out  3  one-hot, combinational grant pulse
- rvalid  out  3  one-hot, registered read-data valid
- rdata  out  DW  read data, valid when any rvalid bit is set
- oSRAM_ADDR  out  AW  registered address
- oSRAM_OE_N  out  1  registered output enable, active-low
- oSRAM_WE_N  out  1  registered write enable, active-low
- oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  out  1 each  constant 0
- ioSRAM_DQ  inout  DW  driven with the registered write data during write cycles, else high-Z

## Operation
- Requester holds req/we/addr/wdata stable until it samples gnt=1. It may change or drop them in the cycle after gnt.
- FSM states:
  - S_IDLE: pins inactive.
  - S_ACCESS: pins carry a granted access.
  - S_TURN: pins inactive and DQ high-Z.
- Arbitration is evaluated every cycle in every state. The winner is:
  - client 0 if req[0];
  - else the round-robin pick of clients 1 and 2.
- Round-robin pointer:
  - Reset value selects client 1.
  - After granting client 1 it points to 2; after granting client 2 it points to 1.
  - A client-0 grant does not move it.
- Turnaround: if the current state is S_ACCESS with a write on the pins and the winner is a read, the grant is withheld.
  - gnt = 0 and next state = S_TURN.
  - Arbitration is re-run in S_TURN with the then-current requests.
- Read followed by a write, or same-direction accesses, need no turnaround and run back-to-back.
- Next state:
  - on a grant: S_ACCESS;
  - no request: S_IDLE;
  - withheld grant: S_TURN.
- In S_ACCESS:
  - write: WE_N=0, OE_N=1, DQ driven.
  - read: OE_N=0, WE_N=1, DQ high-Z.
- Read data on DQ is registered at the end of the S_ACCESS cycle into rdata, with rvalid[i] set for the one following cycle.
- rdata holds its value until the next read completes.

## Timing
- Grant in cycle t drives the pins in t+1. A read returns rvalid/rdata in t+2, so grant-to-rvalid latency is 2 cycles.
- Peak throughput is 1 access/cycle. Each write→read switch costs exactly 1 extra cycle.
- Reset values:
  - gnt=0, rvalid=0, rdata=0;
  - oSRAM_ADDR=0, OE_N=1, WE_N=1, DQ high-Z;
  - state S_IDLE, round-robin pointer at client 1, starve counter 0.
- Reset mid-access: pins return to their reset values asynchronously. The in-flight access is dropped and no rvalid is issued for it.
- Simultaneous requests from all three clients: client 0 wins. The loser among clients 1/2 is granted on the next non-client-0 grant.
- A client whose request is withheld by the turnaround rule sees its gnt in S_TURN at the earliest, if it is still the winner.

## Configuration
- SRAM_ARB_STARVE_EN defined:
  - A counter increments on each client-0 grant while req[1]|req[2].
  - It clears on any client-1/2 grant, or when req[2:1]==0.
  - When it equals STARVE_LIMIT, the next arbitration grants the round-robin pick over client 0, and the counter clears.
- Not defined: the counter is absent and client 0 has strict priority. Clients 1/2 can starve indefinitely.

## Test plan
- Single read by client 2 at addr 0x00960, with the SRAM model returning 0x0101: gnt[2] at t, OE_N=0 and ADDR=0x00960 at t+1, rvalid[2]=1 and rdata=0x0101 at t+2.
- Client 1 writes 0xABCD to 0x00010, then client 2 reads 0x00010 the next cycle: WE_N low for 1 cycle, then a 1-cycle S_TURN with DQ high-Z, then the read returns 0xABCD.
- req=3'b110 held for 6 accesses: grants alternate 1,2,1,2,1,2 with no idle cycles between reads.
- req=3'b111 continuous with SRAM_ARB_STARVE_EN and STARVE_LIMIT=8: 8 client-0 grants, then 1 client-1 grant, 8 client-0 grants, then 1 client-2 grant. Without the macro: only client-0 grants.
- Assert rst_n=0 during a client-2 read's S_ACCESS cycle: OE_N=1, WE_N=1, DQ high-Z immediately, and no rvalid after release.
- Write burst by client 1 while client 0 reads continuously: the client-0 read is never delayed by more than the 1 turnaround cycle.
